// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending dispense controller: product codes,
// prices, the change coin unit, the controller state enumeration and two
// small helpers used by the control FSM (price lookup, coin count).
// -----------------------------------------------------------------------------
package vend_pkg;

   localparam logic [1:0] PROD_SNACK  = 2'd0;
   localparam logic [1:0] PROD_COFFEE = 2'd1;
   localparam logic [1:0] PROD_DRINK  = 2'd2;
   localparam logic [1:0] PROD_CANDY  = 2'd3;

   localparam logic [5:0] PRICE_SNACK  = 6'd30;
   localparam logic [5:0] PRICE_COFFEE = 6'd40;
   localparam logic [5:0] PRICE_DRINK  = 6'd40;
   localparam logic [5:0] PRICE_CANDY  = 6'd30;

   // Change is paid in coins of this value; smaller remainders are kept.
   localparam logic [5:0] COIN_UNIT  = 6'd10;
   // Largest coin count the 3-bit change counter can hold.
   localparam logic [2:0] CHANGE_MAX = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CHECK    = 3'd1,
      ST_DISPENSE = 3'd2,
      ST_CHANGE   = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   function automatic logic [5:0] price_of(input logic [1:0] prod);
      logic [5:0] p;
      case (prod)
         PROD_SNACK:  p = PRICE_SNACK;
         PROD_COFFEE: p = PRICE_COFFEE;
         PROD_DRINK:  p = PRICE_DRINK;
         default:     p = PRICE_CANDY;
      endcase
      return p;
   endfunction

   // Whole coins contained in an amount, truncated and saturated to the
   // width of the change counter.
   function automatic logic [2:0] coins_of(input logic [5:0] amount);
      logic [5:0] q;
      q = amount / COIN_UNIT;
      if (q > {3'b000, CHANGE_MAX}) begin
         return CHANGE_MAX;
      end
      return q[2:0];
   endfunction

endpackage

// File: rtl/vend_timer.sv
// -----------------------------------------------------------------------------
// vend_timer
// 8-bit watchdog counter for the dispense motor. Counts cycles while enabled,
// restarts from zero while clear is high, and flags expire during the
// TIMEOUT_CYC-th enabled cycle so the controller can leave on that edge.
//
// Ports:
//   clock  in  rising-edge clock
//   reset  in  asynchronous active-high reset
//   enable in  count this cycle
//   clear  in  restart count from zero
//   expire out TIMEOUT_CYC enabled cycles have elapsed (combinational)
// -----------------------------------------------------------------------------
module vend_timer #(
   parameter int unsigned TIMEOUT_CYC = 200
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic expire
);

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = 8'd0;
      end else if (enable) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   // count_q is 0 in the first enabled cycle, so LAST_CNT marks cycle N.
   assign expire = enable && !clear && (count_q == LAST_CNT);

endmodule

// File: rtl/vend_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// vend_dispense_ctrl
// Vending machine dispense controller. Accepts a request with product and
// credit, checks the price, runs the dispense motor, then pays change (or a
// refund) one 10-coin at a time through the hopper handshake.
//
// Optional feature: define VEND_TIMEOUT_EN to add a motor watchdog
// (vend_timer). On expiry the motor is stopped, the sticky fault flag is set
// and the full credit is refunded. Without it, DISPENSE waits indefinitely
// and fault is constant 0.
//
// Ports:
//   clock        in  rising-edge clock
//   reset        in  asynchronous active-high reset
//   req          in  vend request, sampled in IDLE
//   product[1:0] in  0 snack, 1 coffee, 2 drink, 3 candy
//   credit[5:0]  in  inserted credit
//   cancel       in  abort, honoured in IDLE and CHECK only
//   motor_done   in  dispense motor finished
//   hopper_ack   in  hopper released one coin
//   busy         out not in IDLE
//   motor_sel    out latched product
//   motor_go     out dispense command
//   hopper_pulse out coin release request
//   change_cnt   out coins still owed
//   done         out one-cycle completion pulse
//   nack         out one-cycle insufficient-credit pulse
//   fault        out sticky motor timeout flag
// -----------------------------------------------------------------------------
module vend_dispense_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 200
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req,
   input  logic [1:0] product,
   input  logic [5:0] credit,
   input  logic       cancel,
   input  logic       motor_done,
   input  logic       hopper_ack,
   output logic       busy,
   output logic [1:0] motor_sel,
   output logic       motor_go,
   output logic       hopper_pulse,
   output logic [2:0] change_cnt,
   output logic       done,
   output logic       nack,
   output logic       fault
);

   import vend_pkg::*;

   state_t     state_q,  state_d;
   logic [1:0] prod_q,   prod_d;
   logic [5:0] credit_q, credit_d;
   logic [2:0] cnt_q,    cnt_d;
   logic       hp_q,     hp_d;
   logic       nack_q,   nack_d;

   logic       in_dispense;
   logic       timer_expire;
   logic       timeout_fire;

   assign in_dispense = (state_q == ST_DISPENSE);

`ifdef VEND_TIMEOUT_EN
   logic fault_q, fault_d;

   vend_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .enable (in_dispense),
      .clear  (!in_dispense),
      .expire (timer_expire)
   );

   always_comb begin
      fault_d = fault_q | timeout_fire;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end

   assign fault = fault_q;
`else
   // The parameter is only consumed when the watchdog is built in.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^(8'(TIMEOUT_CYC));
   assign timer_expire       = 1'b0;
   assign fault              = 1'b0;
`endif

   // A motor_done in the expiry cycle still counts as a normal dispense.
   assign timeout_fire = in_dispense && !motor_done && timer_expire;

   always_comb begin
      state_d  = state_q;
      prod_d   = prod_q;
      credit_d = credit_q;
      cnt_d    = cnt_q;
      hp_d     = 1'b0;
      nack_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Cancel wins over req; the live credit is refunded and the
            // previously latched product is left untouched.
            if (cancel) begin
               cnt_d   = coins_of(credit);
               state_d = ST_CHANGE;
            end else if (req) begin
               prod_d   = product;
               credit_d = credit;
               state_d  = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (cancel) begin
               cnt_d   = coins_of(credit_q);
               state_d = ST_CHANGE;
            end else if (credit_q >= price_of(prod_q)) begin
               cnt_d   = coins_of(credit_q - price_of(prod_q));
               state_d = ST_DISPENSE;
            end else begin
               cnt_d   = coins_of(credit_q);
               nack_d  = 1'b1;
               state_d = ST_CHANGE;
            end
         end
         ST_DISPENSE: begin
            if (motor_done) begin
               state_d = ST_CHANGE;
            end else if (timeout_fire) begin
               cnt_d   = coins_of(credit_q);
               state_d = ST_CHANGE;
            end
         end
         ST_CHANGE: begin
            // hopper_pulse is held until acked, then forced low for one
            // cycle before the next coin; acks while low are ignored.
            if (hp_q) begin
               if (hopper_ack) begin
                  cnt_d = cnt_q - 3'd1;
               end else begin
                  hp_d = 1'b1;
               end
            end else if (cnt_q != 3'd0) begin
               hp_d = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         prod_q   <= 2'd0;
         credit_q <= 6'd0;
         cnt_q    <= 3'd0;
         hp_q     <= 1'b0;
         nack_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         prod_q   <= prod_d;
         credit_q <= credit_d;
         cnt_q    <= cnt_d;
         hp_q     <= hp_d;
         nack_q   <= nack_d;
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign motor_sel    = prod_q;
   assign motor_go     = in_dispense;
   assign hopper_pulse = hp_q;
   assign change_cnt   = cnt_q;
   assign done         = (state_q == ST_DONE);
   assign nack         = nack_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_dispense_ctrl
// Directed bench for vend_dispense_ctrl. Each transaction is described by its
// purchase outcome (dispense, refund, cancel, timeout) and expanded into the
// expected per-cycle output trace: request check, motor phase, coin payout
// with the hopper handshake, done. Outputs are compared with that trace every
// cycle; per-transaction event counts are also pinned to literal values.
// -----------------------------------------------------------------------------
module tb_vend_dispense_ctrl;

   localparam int TMO         = 10;
   localparam int M_REQ       = 0;
   localparam int M_CXL_IDLE  = 1;
   localparam int M_CXL_CHECK = 2;

   typedef struct packed {
      logic       busy;
      logic [1:0] sel;
      logic       go;
      logic       hp;
      logic [2:0] cnt;
      logic       done;
      logic       nack;
      logic       fault;
   } obs_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       req;
   logic [1:0] product;
   logic [5:0] credit;
   logic       cancel;
   logic       motor_done;
   logic       hopper_ack;
   logic       busy;
   logic [1:0] motor_sel;
   logic       motor_go;
   logic       hopper_pulse;
   logic [2:0] change_cnt;
   logic       done;
   logic       nack;
   logic       fault;

   int checks = 0;
   int errors = 0;

   obs_t       exp_q[$];
   logic [1:0] last_sel  = 2'd0;
   logic       fault_exp = 1'b0;

   int   n_go, n_hp_rise, n_nack, n_done, md_cyc, done_cyc, cyc;
   logic hp_prev;

   always #5 clock = ~clock;

   vend_dispense_ctrl #(
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req          (req),
      .product      (product),
      .credit       (credit),
      .cancel       (cancel),
      .motor_done   (motor_done),
      .hopper_ack   (hopper_ack),
      .busy         (busy),
      .motor_sel    (motor_sel),
      .motor_go     (motor_go),
      .hopper_pulse (hopper_pulse),
      .change_cnt   (change_cnt),
      .done         (done),
      .nack         (nack),
      .fault        (fault)
   );

   function automatic obs_t mk(input logic b, input logic [1:0] s, input logic g,
                               input logic h, input int cn, input logic dn,
                               input logic nk, input logic f);
      obs_t o;
      o.busy  = b;
      o.sel   = s;
      o.go    = g;
      o.hp    = h;
      o.cnt   = 3'(cn);
      o.done  = dn;
      o.nack  = nk;
      o.fault = f;
      return o;
   endfunction

   function automatic obs_t mk_idle();
      return mk(1'b0, last_sel, 1'b0, 1'b0, 0, 1'b0, 1'b0, fault_exp);
   endfunction

   function automatic obs_t dut_obs();
      return mk(busy, motor_sel, motor_go, hopper_pulse, int'(change_cnt), done, nack, fault);
   endfunction

   task automatic check_int(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   task automatic check_vec(input string name, input obs_t e);
      obs_t a;
      a = dut_obs();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s @%0t: got busy=%b sel=%0d go=%b hp=%b cnt=%0d done=%b nack=%b fault=%b, expected busy=%b sel=%0d go=%b hp=%b cnt=%0d done=%b nack=%b fault=%b",
                  name, $time, a.busy, a.sel, a.go, a.hp, a.cnt, a.done, a.nack, a.fault,
                  e.busy, e.sel, e.go, e.hp, e.cnt, e.done, e.nack, e.fault);
      end
   endtask

   task automatic monitor();
      if (motor_go) n_go++;
      if (hopper_pulse && !hp_prev) n_hp_rise++;
      hp_prev = hopper_pulse;
      if (nack) n_nack++;
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
      cyc++;
   endtask

   // Expected trace for one transaction, starting with the cycle after the
   // request is sampled. a = cycles hopper_pulse stays high before the ack.
   task automatic build(input logic [1:0] p, input logic [5:0] c, input int mode,
                        input int d, input logic tmo, input int a);
      int         price, coins, chg, ngo;
      logic [1:0] sel;
      logic       nk, flt;
      exp_q.delete();
      price = (p == 2'd1 || p == 2'd2) ? 40 : 30;
      nk    = 1'b0;
      flt   = fault_exp;
      if (mode == M_CXL_IDLE) begin
         sel   = last_sel;
         coins = int'(c) / 10;
      end else begin
         sel      = p;
         last_sel = p;
         exp_q.push_back(mk(1'b1, sel, 1'b0, 1'b0, 0, 1'b0, 1'b0, flt));
         if (mode == M_CXL_CHECK) begin
            coins = int'(c) / 10;
         end else if (int'(c) >= price) begin
            chg = (int'(c) - price) / 10;
            ngo = tmo ? TMO : d;
            for (int k = 0; k < ngo; k++)
               exp_q.push_back(mk(1'b1, sel, 1'b1, 1'b0, chg, 1'b0, 1'b0, flt));
            if (tmo) begin
               coins = int'(c) / 10;
               flt   = 1'b1;
            end else begin
               coins = chg;
            end
         end else begin
            coins = int'(c) / 10;
            nk    = 1'b1;
         end
      end
      if (coins > 7) coins = 7;
      exp_q.push_back(mk(1'b1, sel, 1'b0, 1'b0, coins, 1'b0, nk, flt));
      for (int k = coins; k > 0; k--) begin
         for (int j = 0; j < a; j++)
            exp_q.push_back(mk(1'b1, sel, 1'b0, 1'b1, k, 1'b0, 1'b0, flt));
         exp_q.push_back(mk(1'b1, sel, 1'b0, 1'b0, k - 1, 1'b0, 1'b0, flt));
      end
      exp_q.push_back(mk(1'b1, sel, 1'b0, 1'b0, 0, 1'b1, 1'b0, flt));
      fault_exp = flt;
   endtask

   // Called just after a clock edge in an IDLE cycle that has been checked.
   // spur: drive hopper_ack whenever hopper_pulse should be low.
   // noise: drive cancel during DISPENSE/CHANGE/DONE.
   // hold: keep req high through the transaction and afterwards.
   task automatic run_txn(input string name, input logic [1:0] p, input logic [5:0] c,
                          input int mode, input int d, input logic tmo, input int a,
                          input bit spur, input bit noise, input bit hold, input int abort_at);
      obs_t e;
      int   gocnt, hcnt;
      build(p, c, mode, d, tmo, a);
      n_go = 0; n_hp_rise = 0; n_nack = 0; n_done = 0;
      md_cyc = -1; done_cyc = -2; cyc = 0; hp_prev = 1'b0;
      gocnt = 0; hcnt = 0;
      product = p;
      credit  = c;
      req     = 1'b1;
      cancel  = (mode == M_CXL_IDLE);
      for (int idx = 0; idx < exp_q.size(); idx++) begin
         e = exp_q[idx];
         @(posedge clock); #1;
         check_vec(name, e);
         monitor();
         req     = hold;
         product = ~p;
         credit  = c ^ 6'h2A;
         cancel  = (mode == M_CXL_CHECK && idx == 0) || (noise && idx > 0);
         if (e.go) begin
            gocnt++;
            motor_done = !tmo && (gocnt == d);
            if (motor_done) md_cyc = cyc - 1;
         end else begin
            motor_done = 1'b0;
         end
         if (e.hp) begin
            hcnt++;
            hopper_ack = (hcnt == a);
         end else begin
            hcnt = 0;
            hopper_ack = spur;
         end
         if (idx == abort_at) begin
            reset = 1'b1; req = 1'b0; cancel = 1'b0; motor_done = 1'b0; hopper_ack = 1'b1;
            #1;
            last_sel  = 2'd0;
            fault_exp = 1'b0;
            check_vec({name, " async reset"}, mk_idle());
            @(posedge clock); #1;
            reset = 1'b0;
            for (int k = 0; k < 4; k++) begin
               @(posedge clock); #1;
               check_vec({name, " post-reset idle"}, mk_idle());
               monitor();
            end
            hopper_ack = 1'b0;
            return;
         end
      end
      @(posedge clock); #1;
      check_vec({name, " idle"}, mk_idle());
      monitor();
      cancel = 1'b0; motor_done = 1'b0; hopper_ack = 1'b0;
      if (!hold) req = 1'b0;
   endtask

   task automatic do_reset(input string name);
      reset = 1'b1; req = 1'b0; cancel = 1'b0; motor_done = 1'b0; hopper_ack = 1'b0;
      #1;
      last_sel  = 2'd0;
      fault_exp = 1'b0;
      check_vec({name, " during reset"}, mk_idle());
      @(posedge clock); #1;
      reset = 1'b0;
      check_vec({name, " after reset"}, mk_idle());
   endtask

   initial begin
      reset = 1'b0; req = 1'b0; cancel = 1'b0; motor_done = 1'b0; hopper_ack = 1'b0;
      product = 2'd0; credit = 6'd0;
      #2;
      do_reset("power-on");

      run_txn("coffee50", 2'd1, 6'd50, M_REQ, 5, 1'b0, 2, 1'b0, 1'b0, 1'b0, -1);
      check_int("coffee50 motor_go cycles", n_go, 5);
      check_int("coffee50 hopper pulses", n_hp_rise, 1);
      check_int("coffee50 done pulses", n_done, 1);
      check_int("coffee50 motor_sel", int'(motor_sel), 1);

      run_txn("snack20", 2'd0, 6'd20, M_REQ, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0, -1);
      check_int("snack20 nack pulses", n_nack, 1);
      check_int("snack20 motor_go cycles", n_go, 0);
      check_int("snack20 hopper pulses", n_hp_rise, 2);
      check_int("snack20 done pulses", n_done, 1);

      run_txn("candy30", 2'd3, 6'd30, M_REQ, 3, 1'b0, 1, 1'b0, 1'b0, 1'b0, -1);
      check_int("candy30 hopper pulses", n_hp_rise, 0);
      check_int("candy30 done after motor_done", done_cyc - md_cyc, 2);

      run_txn("req+cancel40", 2'd2, 6'd40, M_CXL_IDLE, 0, 1'b0, 2, 1'b0, 1'b0, 1'b0, -1);
      check_int("req+cancel40 hopper pulses", n_hp_rise, 4);
      check_int("req+cancel40 motor_go cycles", n_go, 0);
      check_int("req+cancel40 motor_sel kept", int'(motor_sel), 3);

      run_txn("drink63 noisy", 2'd2, 6'd63, M_REQ, 2, 1'b0, 1, 1'b1, 1'b1, 1'b0, -1);
      check_int("drink63 hopper pulses", n_hp_rise, 2);
      check_int("drink63 motor_go cycles", n_go, 2);

      run_txn("candy63 cancel-check", 2'd3, 6'd63, M_CXL_CHECK, 0, 1'b0, 1, 1'b1, 1'b0, 1'b0, -1);
      check_int("candy63 hopper pulses", n_hp_rise, 6);
      check_int("candy63 motor_go cycles", n_go, 0);
      check_int("candy63 nack pulses", n_nack, 0);

      run_txn("held req snack30", 2'd0, 6'd30, M_REQ, 1, 1'b0, 1, 1'b0, 1'b0, 1'b1, -1);
      run_txn("held req coffee40", 2'd1, 6'd40, M_REQ, 4, 1'b0, 1, 1'b0, 1'b0, 1'b0, -1);
      check_int("coffee40 motor_go cycles", n_go, 4);

      run_txn("reset mid-change", 2'd0, 6'd20, M_REQ, 0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 3);
      check_int("reset mid-change hopper pulses", n_hp_rise, 1);
      check_int("reset mid-change change_cnt", int'(change_cnt), 0);

`ifdef VEND_TIMEOUT_EN
      run_txn("coffee45 timeout", 2'd1, 6'd45, M_REQ, 0, 1'b1, 1, 1'b0, 1'b0, 1'b0, -1);
      check_int("timeout motor_go cycles", n_go, 10);
      check_int("timeout fault", int'(fault), 1);
      check_int("timeout refund pulses", n_hp_rise, 4);
      run_txn("snack30 after fault", 2'd0, 6'd30, M_REQ, 2, 1'b0, 1, 1'b0, 1'b0, 1'b0, -1);
      check_int("fault sticky", int'(fault), 1);
      do_reset("fault clear");
      check_int("fault cleared by reset", int'(fault), 0);
`else
      run_txn("coffee45 slow motor", 2'd1, 6'd45, M_REQ, 40, 1'b0, 1, 1'b0, 1'b0, 1'b0, -1);
      check_int("slow motor motor_go cycles", n_go, 40);
      check_int("slow motor fault", int'(fault), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vend_dispense_ctrl.md
VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 200, meaning the maximum cycles to wait for motor_done (8-bit range, 1..255).
REQ-002 SHALL have ports `clock  in  1`: single clock, rising edge.
REQ-003 `reset  in  1`: reset is asynchronous and active-high.
REQ-004 `req  in  1`: vend request, sampled in IDLE only.
REQ-005 `product  in  2`: selection: 0 snack, 1 coffee, 2 drink, 3 candy.
REQ-006 `credit  in  6`: inserted credit in units of 1, nominally 0..50.
REQ-007 `cancel  in  1`: abort request.
REQ-008 `motor_done  in  1`: dispense motor completion.
REQ-009 `hopper_ack  in  1`: change hopper has released one 10-coin.
REQ-010 `busy  out  1`: high in every state except IDLE.
REQ-011 `motor_sel  out  2`: latched product.
REQ-012 `motor_go  out  1`: dispense command.
REQ-013 `hopper_pulse  out  1`: coin release request.
REQ-014 `change_cnt  out  3`: coins still owed.
REQ-015 `done  out  1`: one-cycle completion pulse.
REQ-016 `nack  out  1`: one-cycle pulse on insufficient credit.
REQ-017 `fault  out  1`: sticky motor timeout flag.

Function
REQ-018 SHALL implement states IDLE, CHECK, DISPENSE, CHANGE, DONE, each registered.
REQ-019 IDLE with req=1 SHALL latch product/credit and enter CHECK on the next edge; inputs are ignored afterwards until IDLE.
REQ-020 Prices SHALL be snack 30, coffee 40, drink 40, candy 30.
REQ-021 CHECK, credit>=price: SHALL set change_cnt=(credit-price)/10, truncated with the remainder discarded, and go to DISPENSE.
REQ-022 CHECK, credit<price: SHALL set change_cnt=credit/10, pulse nack, and go to CHANGE (refund).
REQ-023 cancel in IDLE or CHECK SHALL go to CHANGE with change_cnt=credit/10 and no dispense; cancel SHALL take priority over req.
REQ-024 cancel in DISPENSE/CHANGE/DONE SHALL be ignored.
REQ-025 DISPENSE: motor_go SHALL be held high until motor_done=1 is sampled, then drop the next cycle; SHALL go to CHANGE.
REQ-026 CHANGE: if change_cnt=0, SHALL go to DONE.
REQ-027 CHANGE with change_cnt>0: SHALL raise hopper_pulse and hold it until hopper_ack.
REQ-028 On hopper_ack in CHANGE: SHALL decrement change_cnt and force hopper_pulse low for at least one cycle before the next coin.
REQ-029 A hopper_ack arriving while hopper_pulse is low SHALL be ignored.
REQ-030 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-031 req held high continuously SHALL start a new transaction on the cycle after DONE.
REQ-032 Credit above 50 SHALL be accepted; change_cnt saturates at 7.

Reset
REQ-033 Asynchronous reset SHALL force state IDLE and all outputs to 0, including fault and change_cnt, at any point, including mid-dispense or mid-payout; owed coins are not retained.

Configuration
REQ-034 With VEND_TIMEOUT_EN defined, an 8-bit counter SHALL run in DISPENSE.
REQ-035 With VEND_TIMEOUT_EN defined, reaching TIMEOUT_CYC without motor_done SHALL drop motor_go, set fault, set change_cnt=credit/10 (full refund), and go to CHANGE.
REQ-036 fault SHALL clear only on reset.
REQ-037 Without VEND_TIMEOUT_EN, DISPENSE SHALL wait indefinitely and fault SHALL be tied to 0.

Structure
REQ-038 Shared package vend_pkg SHALL hold the product code constants, price constants, coin unit (10), and the state enumeration.
REQ-039 The timeout counter SHALL be sub-module vend_timer (enable, clear, expire), instantiated only under VEND_TIMEOUT_EN.

Verification
REQ-040 Coffee, credit 50, motor_done after 5 cycles -> motor_sel=1, motor_go for 5 cycles, one hopper_pulse, change_cnt 1->0, done pulse.
REQ-041 Snack, credit 20 -> nack pulse, no motor_go, two hopper_pulses, done.
REQ-042 Candy, credit 30 -> dispense, zero hopper_pulses, done two cycles after motor_done.
REQ-043 req and cancel in the same cycle, credit 40 -> four coins refunded, motor_go never high.
REQ-044 VEND_TIMEOUT_EN, TIMEOUT_CYC=10, motor_done never asserted -> motor_go drops after 10 cycles, fault=1, credit/10 coins refunded, fault persists until reset.
REQ-045 Reset asserted mid-CHANGE with change_cnt=2 -> immediate IDLE, all outputs 0, no further hopper_pulse.
